// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: buffers ALU commands in a FIFO, issues them one at a time to the
// accumulator ALU and returns result/overflow over a valid/ready response port.
module alu_cmd_issuer #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int OP_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [1:0]       cmd_mode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] num1,
    output logic [WIDTH-1:0] num2,
    output logic [2:0]       in_selector,
    output logic [6:0]       out_selector,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_error,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy,
    output logic [7:0]       err_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = 5 + 2 * WIDTH;
    localparam int WW = $clog2(OP_LAT + 1);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [WW-1:0]    wcnt_q, wcnt_d;
    logic [WIDTH-1:0] num1_q, num1_d, num2_q, num2_d, rsp_data_q, rsp_data_d;
    logic [2:0]       in_sel_q, in_sel_d;
    logic [6:0]       out_sel_q, out_sel_d;
    logic             rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic             push, pop, illegal;
    logic [CW-1:0]    head;
    logic [2:0]       h_op;
    logic [1:0]       h_mode;
    logic [WIDTH-1:0] h_a, h_b;

    function automatic logic [6:0] op_sel(input logic [2:0] op);
        case (op)
            3'd0:    return 7'b1000000;
            3'd1:    return 7'b0100000;
            3'd2:    return 7'b0001000;
            3'd3:    return 7'b0010000;
            3'd4:    return 7'b0000100;
            3'd5:    return 7'b0000010;
            3'd6:    return 7'b0000001;
            default: return 7'b0000000;
        endcase
    endfunction

    assign cmd_ready = cnt_q != FULL;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = state_q == IDLE && cnt_q != '0;
    assign head      = mem_q[rd_q];
    assign {h_op, h_mode, h_a, h_b} = head;
    assign illegal   = h_op == 3'd7 || h_mode == 2'd3;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {cmd_op, cmd_mode, cmd_a, cmd_b};
    end

    always_comb begin
        wr_d        = push ? wr_q + 1'b1 : wr_q;
        rd_d        = pop ? rd_q + 1'b1 : rd_q;
        cnt_d       = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        num1_d      = num1_q;
        num2_d      = num2_q;
        in_sel_d    = in_sel_q;
        out_sel_d   = out_sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        err_cnt_d   = err_cnt_q;
        case (state_q)
            IDLE: if (pop) begin
                if (illegal) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    state_d   = ISSUE;
                    num1_d    = h_a;
                    num2_d    = h_b;
                    in_sel_d  = 3'b100 >> h_mode;
                    out_sel_d = op_sel(h_op);
                end
            end
            ISSUE: begin
                state_d  = WAIT;
                in_sel_d = 3'b100;
                wcnt_d   = WW'(OP_LAT - 1);
            end
            WAIT: if (wcnt_q == '0) begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = alu_result;
                rsp_err_d   = alu_error;
                out_sel_d   = '0;
            end else begin
                wcnt_d = wcnt_q - 1'b1;
            end
            default: if (rsp_ready) begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                err_cnt_d   = (rsp_err_q && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            wcnt_q      <= '0;
            num1_q      <= '0;
            num2_q      <= '0;
            in_sel_q    <= 3'b100;
            out_sel_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            wcnt_q      <= wcnt_d;
            num1_q      <= num1_d;
            num2_q      <= num2_d;
            in_sel_q    <= in_sel_d;
            out_sel_q   <= out_sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign num1         = num1_q;
    assign num2         = num2_q;
    assign in_selector  = in_sel_q;
    assign out_selector = out_sel_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_err      = rsp_err_q;
    assign err_cnt      = err_cnt_q;
    assign busy         = state_q != IDLE || cnt_q != '0;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: directed bench with a behavioural accumulator ALU attached.
module tb_alu_cmd_issuer;
    logic       clk = 0, rst = 1;
    logic       cmd_valid = 0, cmd_ready;
    logic [2:0] cmd_op = 0;
    logic [1:0] cmd_mode = 0;
    logic [7:0] cmd_a = 0, cmd_b = 0;
    logic [7:0] num1, num2, alu_result = 0, rsp_data;
    logic [2:0] in_selector;
    logic [6:0] out_selector;
    logic       alu_error = 0, rsp_valid, rsp_ready = 1, rsp_err, busy;
    logic [7:0] err_cnt;
    int         total = 0, bad = 0, lat;
    logic [8:0] q[$];
    logic       mon_en = 0, sel_bad = 0;
    logic [7:0] acc_m = 0;
    logic [6:0] prev_os = 0;

    alu_cmd_issuer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_mode(cmd_mode), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .num1(num1), .num2(num2), .in_selector(in_selector), .out_selector(out_selector),
        .alu_result(alu_result), .alu_error(alu_error), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Accumulator ALU: latches operands on the cycle out_selector first becomes non-zero
    always @(posedge clk) begin
        logic [7:0]  base;
        logic [15:0] r;
        prev_os <= out_selector;
        if (out_selector != 0 && prev_os == 0) begin
            base = in_selector[1] ? num1 : in_selector[0] ? 8'h00 : acc_m;
            r = 16'h0;
            if (out_selector[6]) r = {8'h0, base & num2};
            if (out_selector[5]) r = {8'h0, base | num2};
            if (out_selector[4]) r = {8'h0, ~base};
            if (out_selector[3]) r = {8'h0, base ^ num2};
            if (out_selector[2]) r = {8'h0, base} + {8'h0, num2};
            if (out_selector[1]) r = (base < num2) ? {8'h1, base - num2} : {8'h0, base - num2};
            if (out_selector[0]) r = base * num2;
            alu_result <= r[7:0];
            alu_error  <= r[15:8] != 0;
            acc_m      <= r[7:0];
        end
    end

    always @(posedge clk) if (rsp_valid && rsp_ready) q.push_back({rsp_err, rsp_data});
    always @(negedge clk) if (mon_en && (in_selector != 3'b100 || out_selector != 0)) sel_bad <= 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] op, input logic [1:0] mode, input logic [7:0] a, input logic [7:0] b);
        int k = 0;
        cmd_op = op; cmd_mode = mode; cmd_a = a; cmd_b = b; cmd_valid = 1;
        while (!cmd_ready && k < 100) begin @(negedge clk); k++; end
        if (k == 100) chk("push_timeout", {31'h0, cmd_ready}, 1);
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic wait_q(input int n);
        int k = 0;
        while (q.size() < n && k < 3000) begin @(negedge clk); k++; end
        chk("rsp_count", q.size(), n);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_in_sel", in_selector, 3'b100);
        chk("rst_out_sel", out_selector, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_num1", num1, 0);
        chk("rst_rsp_data", rsp_data, 0);
        rst = 0;
        @(negedge clk);
        // load 5 then add 3, measuring latency from the push edge
        cmd_op = 4; cmd_mode = 1; cmd_a = 8'h05; cmd_b = 8'h03; cmd_valid = 1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        cmd_valid = 0;
        while (!rsp_valid && lat < 20) begin @(posedge clk); lat++; @(negedge clk); end
        chk("add_latency", lat, 4);
        wait_q(1);
        chk("add_rsp", q[0], {1'b0, 8'h08});
        q.delete();
        push(0, 1, 8'h10, 8'hFF);
        push(6, 0, 8'h00, 8'h20);
        wait_q(2);
        chk("load_and", q[0], {1'b0, 8'h10});
        chk("mult_ovf", q[1], {1'b1, 8'h00});
        chk("err_cnt_1", err_cnt, 1);
        q.delete();
        // five commands with the consumer stalled
        rsp_ready = 0;
        push(4, 1, 8'h01, 8'h01);
        push(4, 0, 8'h00, 8'h01);
        push(4, 0, 8'h00, 8'h02);
        push(2, 0, 8'h00, 8'h0F);
        push(1, 2, 8'h00, 8'h33);
        chk("fifo_full_ready", cmd_ready, 0);
        for (int i = 0; i < 4; i++) begin
            chk("held_valid", rsp_valid, 1);
            chk("held_data", rsp_data, 8'h02);
            @(negedge clk);
        end
        rsp_ready = 1;
        wait_q(5);
        chk("order0", q[0], {1'b0, 8'h02});
        chk("order1", q[1], {1'b0, 8'h03});
        chk("order2", q[2], {1'b0, 8'h05});
        chk("order3", q[3], {1'b0, 8'h0A});
        chk("order4", q[4], {1'b0, 8'h33});
        chk("idle_busy", busy, 0);
        q.delete();
        // illegal commands never drive the ALU
        mon_en = 1;
        push(7, 1, 8'hAA, 8'h55);
        push(4, 3, 8'hAA, 8'h55);
        wait_q(2);
        mon_en = 0;
        chk("illegal_op", q[0], {1'b1, 8'h00});
        chk("illegal_mode", q[1], {1'b1, 8'h00});
        chk("illegal_sel", sel_bad, 0);
        chk("err_cnt_3", err_cnt, 3);
        q.delete();
        // reset while waiting on the ALU
        cmd_op = 4; cmd_mode = 1; cmd_a = 8'h01; cmd_b = 8'h01; cmd_valid = 1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("wait_in_sel", in_selector, 3'b100);
        chk("wait_out_sel", out_selector, 7'b0000100);
        rst = 1;
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        chk("mid_rst_in_sel", in_selector, 3'b100);
        chk("mid_rst_out_sel", out_selector, 0);
        chk("mid_rst_err_cnt", err_cnt, 0);
        @(negedge clk);
        rst = 0;
        repeat (10) @(negedge clk);
        chk("no_stale_rsp", q.size(), 0);
        chk("no_stale_valid", rsp_valid, 0);
        // saturate the error counter
        for (int i = 0; i < 255; i++) push(7, 2'(i), 8'h00, 8'h00);
        wait_q(255);
        chk("err_cnt_255", err_cnt, 8'hFF);
        push(4, 3, 8'h00, 8'h00);
        wait_q(256);
        chk("err_cnt_sat", err_cnt, 8'hFF);
        chk("sat_last_rsp", q[255], {1'b1, 8'h00});
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
